seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu_comb.sv | 53 +++++
 rtl/seq_alu.sv | 130 +++++++++++++
 tb/tb_seq_alu.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: operation codes and FSM states.
package alu_pkg;

  localparam logic [2:0] OP_ABS = 3'd0;
  localparam logic [2:0] OP_SHL = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_NOT = 3'd5;
  localparam logic [2:0] OP_ADD = 3'd6;
  localparam logic [2:0] OP_SUB = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_comb.sv
// Single-cycle result path for every operation except the multi-cycle shift.
module alu_comb
  import alu_pkg::*;
#(
  parameter int W = 12
) (
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic [2:0]   OP,
  output logic [W-1:0] Z,
  output logic         CarryOut,
  output logic         OV
);

  logic [W:0]   sum;
  logic [W:0]   diff;
  logic [W-1:0] neg_a;
  logic [W-1:0] min_val;

  assign sum     = {1'b0, A} + {1'b0, B};
  assign diff    = {1'b0, A} - {1'b0, B};
  assign neg_a   = ~A + 1'b1;
  assign min_val = {1'b1, {(W-1){1'b0}}};

  // Result, carry/borrow and signed overflow selected by operation code.
  always_comb begin
    Z        = '0;
    CarryOut = 1'b0;
    OV       = 1'b0;
    case (OP)
      OP_ABS: begin
        Z  = A[W-1] ? neg_a : A;
        OV = (A == min_val);  // most negative value has no positive twin
      end
      OP_AND: Z = A & B;
      OP_OR:  Z = A | B;
      OP_XOR: Z = A ^ B;
      OP_NOT: Z = ~A;
      OP_ADD: begin
        Z        = sum[W-1:0];
        CarryOut = sum[W];
        OV       = (A[W-1] == B[W-1]) && (sum[W-1] != A[W-1]);
      end
      OP_SUB: begin
        Z        = diff[W-1:0];
        CarryOut = diff[W];  // borrow: A < B unsigned
        OV       = (A[W-1] != B[W-1]) && (diff[W-1] != A[W-1]);
      end
      default: ;  // shift is handled sequentially in the top
    endcase
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: accepts one request in IDLE, performs shifts one bit per
// clock in SHIFT, and holds the result in DONE until the consumer takes it.
// Handshake: a request transfers on a rising edge with in_valid && in_ready;
// a result transfers on a rising edge with out_valid && out_ready. in_ready
// and out_valid are never high together, so no request is taken on the edge
// that retires a result.
module seq_alu
  import alu_pkg::*;
#(
  parameter int W  = 12,
  parameter int SW = $clog2(W) + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic [2:0]   OP,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] Z,
  output logic         CarryOut,
  output logic         Sign,
  output logic         OV,
  output logic         ov_sticky,
  input  logic         clr_sticky,
  output logic [1:0]   fsm_state
);

  localparam logic [SW-1:0] W_CNT = SW'(W);

  state_t        state;
  state_t        state_nxt;
  logic [SW-1:0] cnt;
  logic [SW-1:0] shamt;
  logic [W-1:0]  z_q;
  logic          c_q;
  logic          ov_q;
  logic          sticky_q;
  logic          accept;
  logic [W-1:0]  comb_z;
  logic          comb_c;
  logic          comb_ov;

  alu_comb #(.W(W)) u_comb (
    .A        (A),
    .B        (B),
    .OP       (OP),
    .Z        (comb_z),
    .CarryOut (comb_c),
    .OV       (comb_ov)
  );

  // Shift distance saturates at W: anything larger still clears the word.
  assign shamt  = (A[SW-1:0] > W_CNT) ? W_CNT : A[SW-1:0];
  assign accept = in_valid && (state == IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic and handshake flags.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (OP == OP_SHL && shamt != '0) state_nxt = SHIFT;
          else                             state_nxt = DONE;
        end
      end
      SHIFT: begin
        if (cnt == SW'(1)) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Result registers double as the shift working register; they only change
  // on accept or while shifting, so late operand changes cannot leak in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_q  <= '0;
      c_q  <= 1'b0;
      ov_q <= 1'b0;
      cnt  <= '0;
    end else if (accept) begin
      if (OP == OP_SHL) begin
        z_q  <= B;
        c_q  <= 1'b0;
        ov_q <= 1'b0;
        cnt  <= shamt;
      end else begin
        z_q  <= comb_z;
        c_q  <= comb_c;
        ov_q <= comb_ov;
        cnt  <= '0;
      end
    end else if (state == SHIFT) begin
      c_q <= z_q[W-1];
      z_q <= {z_q[W-2:0], 1'b0};
      cnt <= cnt - 1'b1;
    end
  end

  // Sticky overflow: set when an overflowing result is retired; set beats clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                     sticky_q <= 1'b0;
    else if (state == DONE && out_ready && ov_q)    sticky_q <= 1'b1;
    else if (clr_sticky)                            sticky_q <= 1'b0;
  end

  assign Z         = z_q;
  assign CarryOut  = c_q;
  assign Sign      = z_q[W-1];
  assign OV        = ov_q;
  assign ov_sticky = sticky_q;
  assign fsm_state = state;

endmodule

// File: tb/tb_seq_alu.sv
// Directed-vector bench for seq_alu at W=12.
module tb_seq_alu;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] A;
  logic [11:0] B;
  logic [2:0]  OP;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] Z;
  logic        CarryOut;
  logic        Sign;
  logic        OV;
  logic        ov_sticky;
  logic        clr_sticky;
  logic [1:0]  fsm_state;

  int n_cmp = 0;
  int n_err = 0;

  seq_alu #(.W(12)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .A          (A),
    .B          (B),
    .OP         (OP),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .Z          (Z),
    .CarryOut   (CarryOut),
    .Sign       (Sign),
    .OV         (OV),
    .ov_sticky  (ov_sticky),
    .clr_sticky (clr_sticky),
    .fsm_state  (fsm_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one request at a negedge, then count clocks until out_valid.
  task automatic run_op(input logic [11:0] a, input logic [11:0] b,
                        input logic [2:0] op, output int lat);
    @(negedge clk);
    A = a; B = b; OP = op; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 64) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Retire the held result (ends on the negedge after the taking edge).
  task automatic take();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic clear_sticky();
    clr_sticky = 1'b1;
    @(negedge clk);
    clr_sticky = 1'b0;
  endtask

  // Full transaction with checks of latency, result, flags and sticky.
  task automatic op_check(input string tag, input logic [11:0] a, input logic [11:0] b,
                          input logic [2:0] op, input int exp_lat, input logic [11:0] ez,
                          input logic ec, input logic eov);
    int lat;
    check({tag, ".rdy"}, in_ready, 1);
    run_op(a, b, op, lat);
    check({tag, ".lat"}, lat, exp_lat);
    check({tag, ".z"}, Z, ez);
    check({tag, ".c"}, CarryOut, ec);
    check({tag, ".ov"}, OV, eov);
    check({tag, ".sign"}, Sign, ez[11]);
    take();
    check({tag, ".idle"}, fsm_state, 0);
    check({tag, ".sticky"}, ov_sticky, eov);
    clear_sticky();
  endtask

  initial begin
    int lat;
    rst_n = 1'b0; in_valid = 1'b0; A = '0; B = '0; OP = '0;
    out_ready = 1'b0; clr_sticky = 1'b0;
    #1;
    check("rst.in_ready", in_ready, 1);
    check("rst.out_valid", out_valid, 0);
    check("rst.z", Z, 0);
    check("rst.c", CarryOut, 0);
    check("rst.sign", Sign, 0);
    check("rst.ov", OV, 0);
    check("rst.sticky", ov_sticky, 0);
    check("rst.state", fsm_state, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    //       tag        A       B       OP lat  Z       C     OV
    op_check("abs_min", 12'h800, 12'h000, 0, 1, 12'h800, 1'b0, 1'b1);
    op_check("abs_neg", 12'hFFD, 12'h000, 0, 1, 12'h003, 1'b0, 1'b0);
    op_check("abs_pos", 12'h123, 12'hFFF, 0, 1, 12'h123, 1'b0, 1'b0);
    op_check("add_ov",  12'h7FF, 12'h001, 6, 1, 12'h800, 1'b0, 1'b1);
    op_check("add_cy",  12'hFFF, 12'h001, 6, 1, 12'h000, 1'b1, 1'b0);
    op_check("sub_brw", 12'h001, 12'h002, 7, 1, 12'hFFF, 1'b1, 1'b0);
    op_check("sub_ov",  12'h800, 12'h001, 7, 1, 12'h7FF, 1'b0, 1'b1);
    op_check("and",     12'hF0F, 12'h0FF, 2, 1, 12'h00F, 1'b0, 1'b0);
    op_check("or",      12'hF0F, 12'h0FF, 3, 1, 12'hFFF, 1'b0, 1'b0);
    op_check("xor",     12'hF0F, 12'h0FF, 4, 1, 12'hFF0, 1'b0, 1'b0);
    op_check("not",     12'h5A5, 12'h000, 5, 1, 12'hA5A, 1'b0, 1'b0);
    op_check("shl3",    12'h003, 12'hA01, 1, 4, 12'h008, 1'b1, 1'b0);
    op_check("shl3_hi", 12'h0E3, 12'hA01, 1, 4, 12'h008, 1'b1, 1'b0);
    op_check("shl0",    12'h000, 12'h123, 1, 1, 12'h123, 1'b0, 1'b0);
    op_check("shl1",    12'h001, 12'h800, 1, 2, 12'h000, 1'b1, 1'b0);
    op_check("shl13",   12'h00D, 12'h123, 1, 13, 12'h000, 1'b1, 1'b0);
    op_check("shl12",   12'h00C, 12'h802, 1, 13, 12'h000, 1'b0, 1'b0);

    // Backpressure: result held while operands churn and in_valid stays high.
    run_op(12'h100, 12'h023, 3'd6, lat);
    check("bp.lat", lat, 1);
    for (int i = 0; i < 5; i++) begin
      A = 12'h3C5 + 12'(i * 37); B = 12'hABC - 12'(i * 11); OP = 3'(i + 2);
      in_valid = 1'b1;
      @(negedge clk);
      check("bp.z", Z, 12'h123);
      check("bp.in_ready", in_ready, 0);
      check("bp.out_valid", out_valid, 1);
    end
    A = 12'h001; B = 12'h001; OP = 3'd6;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp.no_b2b_state", fsm_state, 0);
    check("bp.no_b2b_valid", out_valid, 0);
    check("bp.in_ready", in_ready, 1);
    in_valid = 1'b0;

    // Sticky set and clear on the same edge: set wins.
    run_op(12'h7FF, 12'h7FF, 3'd6, lat);
    check("ss.z", Z, 12'hFFE);
    check("ss.ov", OV, 1);
    out_ready = 1'b1; clr_sticky = 1'b1;
    @(negedge clk);
    out_ready = 1'b0; clr_sticky = 1'b0;
    check("ss.sticky", ov_sticky, 1);

    // Reset in the middle of a shift discards everything, sticky included.
    @(negedge clk);
    A = 12'h00A; B = 12'hFFF; OP = 3'd1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("rs.shifting", fsm_state, 1);
    rst_n = 1'b0;
    #1;
    check("rs.out_valid", out_valid, 0);
    check("rs.z", Z, 0);
    check("rs.c", CarryOut, 0);
    check("rs.in_ready", in_ready, 1);
    check("rs.state", fsm_state, 0);
    check("rs.sticky", ov_sticky, 0);
    @(negedge clk);
    rst_n = 1'b1;
    op_check("post_rst", 12'h00F, 12'h0F0, 3, 1, 12'h0FF, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
